// File: rtl/usb_utm_rx.sv
// Full-speed USB UTM receiver: pin sync, bit recovery, NRZI decode, SYNC/unstuff/byte/EOP.
// Define USB_UTM_RX_STUFF_ERR_EN to flag a 1 in a stuff position as a receive error.
module usb_utm_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int STUFF_BITS_N   = 6,
   parameter int SYNC_TIMEOUT   = 16,
   parameter int SE0_RESET_BITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dp_rx,
   input  logic       dn_rx,
   input  logic       tx_oen,
   output logic [1:0] line_state,
   output logic       rx_active,
   output logic       rx_valid,
   output logic       rx_error,
   output logic [7:0] data_out
);

   localparam int OW = $clog2(STUFF_BITS_N + 1);
   localparam int CW = 8;
   localparam logic [OW-1:0] STUFF_POS = OW'(STUFF_BITS_N);
   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_TIMEOUT - 1);
   localparam logic [CW-1:0] SE0_LAST  = CW'(SE0_RESET_BITS - 1);
   localparam logic [CW-1:0] J_LAST    = CW'(7);

   typedef enum logic [2:0] {IDLE_S, SYNC_S, DATA_S, EOP_S, ERR_S} state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] dp_sync_reg, dn_sync_reg;
   logic [1:0]             line_state_reg;
   logic [1:0]             phase_reg;
   logic                   prev_reg;
   logic [6:0]             shift_reg, shift_next;
   logic [2:0]             bit_reg, bit_next;
   logic [OW-1:0]          ones_reg, ones_next;
   logic [1:0]             zero_reg, zero_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic                   se0_seen_reg, se0_seen_next;
   logic [7:0]             data_reg, data_next;
   logic                   valid_reg, valid_next;
   logic                   error_reg, error_next;

   logic dp_s, dn_s, smp_dp, smp_dn, strobe;
   logic smp_se0, smp_se1, smp_jk, smp_k, dbit, stuff_pos;

   assign dp_s      = dp_sync_reg[SYNC_STAGES-1];
   assign dn_s      = dn_sync_reg[SYNC_STAGES-1];
   assign smp_dp    = line_state_reg[0];
   assign smp_dn    = line_state_reg[1];
   assign strobe    = (phase_reg == 2'd2);
   assign smp_se0   = strobe && !smp_dp && !smp_dn;
   assign smp_se1   = strobe && smp_dp && smp_dn;
   assign smp_jk    = strobe && (smp_dp ^ smp_dn);
   assign smp_k     = smp_jk && !smp_dp;
   assign dbit      = (smp_dp == prev_reg);
   assign stuff_pos = (ones_reg == STUFF_POS);

   assign line_state = line_state_reg;
   assign rx_valid   = valid_reg;
   assign rx_error   = error_reg;
   assign data_out   = data_reg;

   // The phase counter restarts when the fully synchronised dp differs from its
   // delayed copy, so the sample lands two clocks into each bit of line_state_reg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_sync_reg    <= '1;
         dn_sync_reg    <= '0;
         line_state_reg <= 2'b01;
         phase_reg      <= 2'd0;
      end else begin
         dp_sync_reg    <= {dp_sync_reg[SYNC_STAGES-2:0], dp_rx};
         dn_sync_reg    <= {dn_sync_reg[SYNC_STAGES-2:0], dn_rx};
         line_state_reg <= {dn_s, dp_s};
         phase_reg      <= (dp_s != line_state_reg[0]) ? 2'd0 : phase_reg + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE_S;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (tx_oen) begin
         state_next = IDLE_S;
      end else begin
         case (state_reg)
            IDLE_S: if (smp_k) state_next = SYNC_S;
            SYNC_S: begin
               if (smp_se0 || smp_se1)
                  state_next = IDLE_S;
               else if (smp_jk) begin
                  if (dbit)
                     state_next = (zero_reg == 2'd3) ? DATA_S : IDLE_S;
                  else if (cnt_reg >= SYNC_LAST)
                     state_next = IDLE_S;
               end
            end
            DATA_S: begin
               if (smp_se1)
                  state_next = ERR_S;
               else if (smp_se0)
                  state_next = EOP_S;
`ifdef USB_UTM_RX_STUFF_ERR_EN
               else if (smp_jk && stuff_pos && dbit)
                  state_next = ERR_S;
`endif
            end
            EOP_S: begin
               if (smp_jk && smp_dp)
                  state_next = IDLE_S;
               else if (smp_se0 && cnt_reg >= SE0_LAST)
                  state_next = IDLE_S;
            end
            ERR_S: if (smp_jk && smp_dp && (se0_seen_reg || cnt_reg >= J_LAST)) state_next = IDLE_S;
            default: state_next = IDLE_S;
         endcase
      end
   end

   always_comb begin
      rx_active     = (state_reg == DATA_S) || (state_reg == EOP_S) || (state_reg == ERR_S);
      shift_next    = shift_reg;
      bit_next      = bit_reg;
      ones_next     = ones_reg;
      zero_next     = zero_reg;
      cnt_next      = cnt_reg;
      se0_seen_next = se0_seen_reg;
      data_next     = data_reg;
      valid_next    = 1'b0;
      error_next    = 1'b0;
      if (!tx_oen) begin
         case (state_reg)
            IDLE_S: begin
               if (smp_k) begin
                  zero_next = 2'd1;
                  cnt_next  = CW'(1);
               end
            end
            SYNC_S: begin
               if (smp_jk) begin
                  if (dbit) begin
                     bit_next  = 3'd0;
                     ones_next = '0;
                  end else begin
                     zero_next = (zero_reg == 2'd3) ? 2'd3 : zero_reg + 2'd1;
                     cnt_next  = cnt_reg + CW'(1);
                  end
               end
            end
            DATA_S: begin
               cnt_next      = '0;
               se0_seen_next = 1'b0;
               if (smp_se1) begin
                  error_next = 1'b1;
               end else if (smp_se0) begin
                  error_next = (bit_reg != 3'd0);
                  cnt_next   = CW'(1);
               end else if (smp_jk) begin
                  if (stuff_pos) begin
                     ones_next = '0;
`ifdef USB_UTM_RX_STUFF_ERR_EN
                     if (dbit) error_next = 1'b1;
`endif
                  end else begin
                     shift_next = {dbit, shift_reg[6:1]};
                     ones_next  = dbit ? ones_reg + OW'(1) : '0;
                     bit_next   = bit_reg + 3'd1;
                     if (bit_reg == 3'd7) begin
                        data_next  = {dbit, shift_reg};
                        valid_next = 1'b1;
                     end
                  end
               end
            end
            EOP_S: if (smp_se0) cnt_next = cnt_reg + CW'(1);
            ERR_S: begin
               // Counts consecutive J samples; an SE0 arms the J-after-SE0 exit.
               if (smp_jk && smp_dp) begin
                  cnt_next = cnt_reg + CW'(1);
               end else if (smp_se0) begin
                  cnt_next      = '0;
                  se0_seen_next = 1'b1;
               end else if (strobe) begin
                  cnt_next      = '0;
                  se0_seen_next = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_reg     <= 1'b1;
         shift_reg    <= '0;
         bit_reg      <= '0;
         ones_reg     <= '0;
         zero_reg     <= '0;
         cnt_reg      <= '0;
         se0_seen_reg <= 1'b0;
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         if (state_next == IDLE_S) prev_reg <= 1'b1;
         else if (smp_jk)          prev_reg <= smp_dp;
         shift_reg    <= shift_next;
         bit_reg      <= bit_next;
         ones_reg     <= ones_next;
         zero_reg     <= zero_next;
         cnt_reg      <= cnt_next;
         se0_seen_reg <= se0_seen_next;
         data_reg     <= data_next;
         valid_reg    <= valid_next;
         error_reg    <= error_next;
      end
   end

endmodule

// File: doc/usb_utm_rx.md
Name: usb_utm_rx

Overview:
UTM receive side for full-speed USB (12 Mbit/s, clk = 48 MHz, 4 clk per bit). Synchronises raw D+/D- and recovers bit timing with an edge-aligned phase counter. Performs NRZI decoding, SYNC detection, bit unstuffing, byte assembly and EOP detection, and presents the UTMI receive interface to the SIE. It is the receive companion of the UTM transmitter and is muted while that transmitter drives the bus.

Parameters:
SYNC_STAGES, 2, number of metastability flops on dp_rx/dn_rx (>=2)
STUFF_BITS_N, 6, consecutive decoded ones after which a stuffed zero is expected
SYNC_TIMEOUT, 16, bit times allowed in SYNC_S before abandoning to IDLE_S
SE0_RESET_BITS, 8, bit times of continuous SE0 after which EOP_S gives up waiting for J

Ports:
clk         input   1  48 MHz clock
rst         input   1  reset, asynchronous, active-high
dp_rx       input   1  USB D+ from frontend receiver, asynchronous
dn_rx       input   1  USB D- from frontend receiver, asynchronous
tx_oen      input   1  transmitter output enable; high = own transmission on bus
line_state  output  2  UTMI LineState {dn_s,dp_s}: 00 SE0, 01 J, 10 K, 11 SE1
rx_active   output  1  packet in progress (SYNC found, EOP/idle not yet reached)
rx_valid    output  1  one-clk strobe: data_out holds a new byte
rx_error    output  1  one-clk strobe: receive error detected
data_out    output  8  received byte, LSB received first

Behaviour:
- Reset (async): synchroniser flops = J (dp=1, dn=0). line_state=01, rx_active=0, rx_valid=0, rx_error=0, data_out=0x00, FSM=IDLE_S. Reset mid-packet aborts immediately; no strobes are emitted.
- line_state is registered from the synchronised pair; latency from a pin change = SYNC_STAGES+1 clk.
- Bit clock recovery: 2-bit phase counter. Cleared to 0 on any J<->K change of synchronised dp, otherwise increments and wraps 3->0. Sample strobe when phase==2. The result tolerates +/-1 clk edge jitter per bit.
- NRZI: decoded bit = 1 if the sampled J/K level equals the previous sample, else 0. Previous sample is forced to J in IDLE_S.
- FSM states:
  - IDLE_S: wait for a sampled K, then go to SYNC_S.
  - SYNC_S: count decoded zeros. A decoded 1 after >=3 zeros goes to DATA_S, sets rx_active=1 on the next clk, and clears the bit and ones counters. A decoded 1 after <3 zeros, a sampled SE0, or SYNC_TIMEOUT bits elapsed returns to IDLE_S silently.
  - DATA_S: run the unstuffer. After STUFF_BITS_N consecutive ones, the next bit is discarded if 0 (ones counter cleared). A 1 in that position is a stuff error (see Optional Feature). Bits are shifted into the byte LSB-first. On the 8th bit, data_out is loaded and rx_valid pulses 1 clk later. A sampled SE0 goes to EOP_S; if the bit count != 0 at that point, rx_error pulses and the partial byte is dropped.
  - EOP_S: wait for a sampled J, then IDLE_S, with rx_active=0 on the next clk. SE0 lasting SE0_RESET_BITS also goes to IDLE_S.
  - ERR_S: rx_active stays 1. Exit to IDLE_S, with rx_active=0, once a sampled J follows SE0, or after 8 consecutive J samples.
- A sampled SE1 in DATA_S: rx_error pulse, go to ERR_S.
- tx_oen=1: FSM forced to IDLE_S, rx_active=0, no strobes. A packet in progress is dropped without rx_error. The bit recovery logic keeps running.
- rx_valid and rx_error never assert while rx_active=0. They are never asserted in the same clk; rx_error has priority.
- data_out holds its value until the next byte is loaded.

Optional Feature:
USB_UTM_RX_STUFF_ERR_EN:
- Defined: a decoded 1 in a stuff position in DATA_S pulses rx_error, discards the current byte, and goes to ERR_S.
- Undefined: that bit is discarded as if it were a stuffed zero, the ones counter is cleared, and reception continues with no error.

Test Plan:
- Idle J, then SYNC (KJKJKJKK), bytes 0xC3 and 0x5A, SE0 x2 bits, J -> rx_active rises after the final K. rx_valid pulses twice with data_out 0xC3 then 0x5A. rx_active falls after J. rx_error stays 0.
- Bytes 0xFF 0xFF with correct stuffed zeros -> two rx_valid strobes, both data_out 0xFF. No stuffed bit appears in data.
- Macro defined: byte 0x7F followed by 0x01, sent without the stuffed zero (7 ones) -> one rx_error pulse, no rx_valid for that byte, then rx_active=0 after EOP. Macro undefined: same stimulus gives no rx_error.
- Packet with bit periods alternating 3 and 5 clk, bytes 0x96 0x3C -> data_out 0x96, 0x3C exactly.
- SYNC + 0xA5 + 5 bits + EOP -> rx_valid once (0xA5), then one rx_error pulse at SE0.
- tx_oen=1 held across a full valid packet -> rx_active, rx_valid, rx_error all stay 0. line_state still tracks the pins.
